// File: rtl/core_pipe_ctrl.sv
`timescale 1ns/1ps
// Stage sequencer: drives per-stage enables from finish strobes, one token (multicycle) or one per stage (pipelined).
// Latency: a token moves one stage per edge once finished; retire pulse is combinational on the last stage's finish.
// Backpressure: a finished stage whose successor is occupied and not advancing holds its token with its enable dropped.
module core_pipe_ctrl #(
    parameter int NSTAGE    = 3,
    parameter int PIPE_MODE = 1,
    parameter int CNT_W     = 32,
    parameter int IDX_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NSTAGE-1:0] i_stage_finish,
    input  logic              i_flush,
    input  logic              i_halt,
    output logic [NSTAGE-1:0] o_stage_en,
    output logic [NSTAGE-1:0] o_stage_vld,
    output logic              o_busy,
    output logic              o_retire,
    output logic [CNT_W-1:0]  o_retire_cnt,
    output logic [IDX_W-1:0]  o_active_idx
);

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] done;
    logic [NSTAGE-1:0] fin;
    logic [NSTAGE-1:0] adv;
    logic [NSTAGE-1:0] vld_nxt;
    logic [NSTAGE-1:0] done_nxt;
    logic [CNT_W-1:0]  cnt;

    // A stage is finished if it already latched done or its strobe fires while enabled.
    assign fin = vld & (done | i_stage_finish);

    // Advance chain resolved from the last stage down: a stage moves if its successor is free or moving.
    always_comb begin : adv_chain
        logic [NSTAGE-1:0] a;
        a = '0;
        a[NSTAGE-1] = fin[NSTAGE-1];
        for (int k = NSTAGE - 2; k >= 0; k--) begin
            a[k] = fin[k] & (~vld[k+1] | a[k+1]);
        end
        adv = a;
    end

    // Next occupancy: moves, blocked-finish latching, flush clearing and stage-0 injection.
    always_comb begin : next_state
        logic inj;
        vld_nxt  = vld;
        done_nxt = done;

        if (adv[NSTAGE-1]) begin
            vld_nxt[NSTAGE-1] = 1'b0;
        end else if (fin[NSTAGE-1]) begin
            done_nxt[NSTAGE-1] = 1'b1;
        end

        for (int k = NSTAGE - 2; k >= 0; k--) begin
            if (adv[k]) begin
                vld_nxt[k] = 1'b0;
                // A redirect kills the token instead of handing it on.
                if (!i_flush) begin
                    vld_nxt[k+1]  = 1'b1;
                    done_nxt[k+1] = 1'b0;
                end
            end else if (fin[k]) begin
                done_nxt[k] = 1'b1;
            end
        end

        // Everything upstream of the last stage is on the wrong path after a redirect.
        if (i_flush) begin
            vld_nxt[NSTAGE-2:0]  = '0;
            done_nxt[NSTAGE-2:0] = '0;
        end

        // Multicycle mode only fetches once the lone token is gone; a redirect always refetches.
        if (i_halt) begin
            inj = 1'b0;
        end else if (i_flush) begin
            inj = 1'b1;
        end else if (PIPE_MODE != 0) begin
            inj = ~vld[0] | adv[0];
        end else begin
            inj = (vld_nxt == '0);
        end

        if (inj) begin
            vld_nxt[0]  = 1'b1;
            done_nxt[0] = 1'b0;
        end
    end

    // Lowest occupied stage, zero when empty.
    always_comb begin
        o_active_idx = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (vld[k]) begin
                o_active_idx = IDX_W'(k);
            end
        end
    end

    // State registers; reset discards all tokens and the retire count immediately.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            vld  <= '0;
            done <= '0;
            cnt  <= '0;
        end else begin
            vld  <= vld_nxt;
            done <= done_nxt;
            if (adv[NSTAGE-1]) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_stage_en   = vld & ~done;
    assign o_stage_vld  = vld;
    assign o_busy       = |vld;
    assign o_retire     = adv[NSTAGE-1];
    assign o_retire_cnt = cnt;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
`timescale 1ns/1ps
// Bench for core_pipe_ctrl: multicycle and pipelined instances share stimulus.
// Expected outputs come from a token-occupancy model and are queued per cycle.
// A negedge monitor pops and compares; directed checks cover the listed scenarios.
module tb_core_pipe_ctrl;

    localparam int NS = 3;

    typedef struct {
        logic [2:0] en;
        logic [2:0] vld;
        logic       busy;
        logic       retire;
        logic [3:0] cnt;
        logic [1:0] idx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] fin_in;
    logic       flush;
    logic       halt;

    logic [2:0] en0, vld0, en1, vld1;
    logic       busy0, ret0, busy1, ret1;
    logic [3:0] cnt0, cnt1;
    logic [1:0] idx0, idx1;

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e_mon;

    // model state: occupancy, finished-flag, retire count per instance (0 = multicycle, 1 = pipelined)
    bit [2:0] occ  [2];
    bit [2:0] dn   [2];
    int       mcnt [2];
    bit [2:0] nocc [2];
    bit [2:0] ndn  [2];
    int       ncnt [2];

    core_pipe_ctrl #(.NSTAGE(3), .PIPE_MODE(0), .CNT_W(4), .IDX_W(2)) u_multi (
        .i_clk(clk), .i_rst(rst), .i_stage_finish(fin_in), .i_flush(flush), .i_halt(halt),
        .o_stage_en(en0), .o_stage_vld(vld0), .o_busy(busy0), .o_retire(ret0),
        .o_retire_cnt(cnt0), .o_active_idx(idx0)
    );

    core_pipe_ctrl #(.NSTAGE(3), .PIPE_MODE(1), .CNT_W(4), .IDX_W(2)) u_pipe (
        .i_clk(clk), .i_rst(rst), .i_stage_finish(fin_in), .i_flush(flush), .i_halt(halt),
        .o_stage_en(en1), .o_stage_vld(vld1), .o_busy(busy1), .o_retire(ret1),
        .o_retire_cnt(cnt1), .o_active_idx(idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which tokens leave their stage this cycle: the last stage leaves when finished;
    // an earlier one leaves when finished and the slot ahead is empty or being vacated.
    function automatic bit [2:0] leave_of(input bit [2:0] o, input bit [2:0] d, input bit [2:0] f);
        bit [2:0] fn;
        bit [2:0] lv;
        fn = o & (d | f);
        lv = '0;
        lv[2] = fn[2];
        lv[1] = fn[1] && (!o[2] || lv[2]);
        lv[0] = fn[0] && (!o[1] || lv[1]);
        return lv;
    endfunction

    function automatic exp_t model_out(input int m, input bit [2:0] f);
        exp_t e;
        bit [2:0] lv;
        lv       = leave_of(occ[m], dn[m], f);
        e.en     = occ[m] & ~dn[m];
        e.vld    = occ[m];
        e.busy   = (occ[m] != 3'b000);
        e.retire = lv[2];
        e.cnt    = 4'(mcnt[m]);
        e.idx    = 2'd0;
        for (int k = 0; k < NS; k++) begin
            if (occ[m][k]) begin
                e.idx = 2'(k);
                break;
            end
        end
        return e;
    endfunction

    task automatic model_step(input int m, input bit [2:0] f, input bit fl, input bit h);
        bit [2:0] o, d, fn, lv, no, nd;
        bit inj;
        o  = occ[m];
        d  = dn[m];
        fn = o & (d | f);
        lv = leave_of(o, d, f);
        no = o;
        nd = d;
        if (lv[2]) no[2] = 1'b0;
        else if (fn[2]) nd[2] = 1'b1;
        for (int k = NS - 2; k >= 0; k--) begin
            if (lv[k]) begin
                no[k] = 1'b0;
                no[k+1] = 1'b1;
                nd[k+1] = 1'b0;
            end else if (fn[k]) begin
                nd[k] = 1'b1;
            end
        end
        if (fl) begin
            // last stage keeps its token unless it just retired; nothing reaches it this edge
            no[0] = 1'b0; no[1] = 1'b0; nd[0] = 1'b0; nd[1] = 1'b0;
            no[2] = o[2] && !lv[2];
            nd[2] = d[2] | fn[2];
        end
        if (h)           inj = 1'b0;
        else if (fl)     inj = 1'b1;
        else if (m == 1) inj = !o[0] || lv[0];
        else             inj = (no == 3'b000);
        if (inj) begin
            no[0] = 1'b1;
            nd[0] = 1'b0;
        end
        nocc[m] = no;
        ndn[m]  = nd;
        ncnt[m] = (mcnt[m] + int'(lv[2])) % 16;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            occ[m] = '0; dn[m] = '0; mcnt[m] = 0;
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance the model across the edge.
    task automatic cycle(input bit [2:0] f, input bit fl, input bit h);
        fin_in = f;
        flush  = fl;
        halt   = h;
        q0.push_back(model_out(0, f));
        q1.push_back(model_out(1, f));
        model_step(0, f, fl, h);
        model_step(1, f, fl, h);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            occ[m] = nocc[m]; dn[m] = ndn[m]; mcnt[m] = ncnt[m];
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en0"},   32'(en0),   32'd0);
        chk({tag, "_vld0"},  32'(vld0),  32'd0);
        chk({tag, "_busy0"}, 32'(busy0), 32'd0);
        chk({tag, "_ret0"},  32'(ret0),  32'd0);
        chk({tag, "_cnt0"},  32'(cnt0),  32'd0);
        chk({tag, "_idx0"},  32'(idx0),  32'd0);
        chk({tag, "_en1"},   32'(en1),   32'd0);
        chk({tag, "_vld1"},  32'(vld1),  32'd0);
        chk({tag, "_busy1"}, 32'(busy1), 32'd0);
        chk({tag, "_ret1"},  32'(ret1),  32'd0);
        chk({tag, "_cnt1"},  32'(cnt1),  32'd0);
        chk({tag, "_idx1"},  32'(idx1),  32'd0);
    endtask

    // Assert reset away from the clock edge, confirm outputs clear before the next edge, release.
    task automatic reset_seq(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        chk_zero(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic [2:0] en, input logic [2:0] vl,
                           input logic bz, input logic rt, input logic [3:0] cn, input logic [1:0] ix);
        chk({tag, "_en"},     32'(en), 32'(e.en));
        chk({tag, "_vld"},    32'(vl), 32'(e.vld));
        chk({tag, "_busy"},   32'(bz), 32'(e.busy));
        chk({tag, "_retire"}, 32'(rt), 32'(e.retire));
        chk({tag, "_cnt"},    32'(cn), 32'(e.cnt));
        chk({tag, "_idx"},    32'(ix), 32'(e.idx));
    endtask

    // Scoreboard monitor: outputs are presented every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e_mon = q0.pop_front();
            cmp_out("multi", e_mon, en0, vld0, busy0, ret0, cnt0, idx0);
        end
        if (q1.size() > 0) begin
            e_mon = q1.pop_front();
            cmp_out("pipe", e_mon, en1, vld1, busy1, ret1, cnt1, idx1);
        end
    end

    logic [2:0] walk [4];
    logic [2:0] drain_vld [3];
    logic [1:0] drain_idx [3];

    initial begin
        walk      = '{3'b001, 3'b010, 3'b100, 3'b001};
        drain_vld = '{3'b110, 3'b100, 3'b000};
        drain_idx = '{2'd1, 2'd2, 2'd0};
        fin_in = 3'b000;
        flush  = 1'b0;
        halt   = 1'b0;
        rst    = 1'b0;
        reset_seq("por");

        // fill: multicycle walks one-hot, pipelined fills in three edges
        for (int i = 0; i < 4; i++) begin
            cycle(3'b111, 1'b0, 1'b0);
            chk("multi_walk_en", 32'(en0), 32'(walk[i]));
            if (i == 2) begin
                chk("pipe_full_en", 32'(en1), 32'b111);
                chk("pipe_full_retire", 32'(ret1), 32'd1);
            end
        end
        for (int i = 0; i < 6; i++) cycle(3'b111, 1'b0, 1'b0);

        // last stage stalls: upstream finished tokens are held with enables dropped
        for (int i = 0; i < 4; i++) begin
            cycle(3'b011, 1'b0, 1'b0);
            chk("stall_en", 32'(en1), 32'b100);
            chk("stall_vld", 32'(vld1), 32'b111);
        end
        for (int i = 0; i < 4; i++) cycle(3'b111, 1'b0, 1'b0);

        // redirect while full: last stage retires, only the refetched token remains
        cycle(3'b111, 1'b1, 1'b0);
        chk("flush_vld", 32'(vld1), 32'b001);
        chk("flush_en", 32'(en1), 32'b001);

        // refill then drain under halt
        for (int i = 0; i < 2; i++) cycle(3'b111, 1'b0, 1'b0);
        chk("refill_vld", 32'(vld1), 32'b111);
        chk("refill_idx", 32'(idx1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b111, 1'b0, 1'b1);
            chk("drain_vld", 32'(vld1), 32'(drain_vld[i]));
            chk("drain_idx", 32'(idx1), 32'(drain_idx[i]));
        end
        chk("drain_busy", 32'(busy1), 32'd0);

        // flush together with halt: nothing is fetched
        for (int i = 0; i < 3; i++) cycle(3'b111, 1'b0, 1'b0);
        chk("pre_fh_vld", 32'(vld1), 32'b111);
        cycle(3'b111, 1'b1, 1'b1);
        chk("flush_halt_vld", 32'(vld1), 32'b000);
        chk("flush_halt_busy", 32'(busy1), 32'd0);

        // mid-operation reset, then counter wrap at 4 bits
        cycle(3'b111, 1'b0, 1'b0);
        reset_seq("midrst");
        for (int i = 0; i < 18; i++) cycle(3'b111, 1'b0, 1'b0);
        chk("wrap_pre_cnt", 32'(cnt1), 32'd15);
        cycle(3'b111, 1'b0, 1'b0);
        chk("wrap_cnt", 32'(cnt1), 32'd0);
        chk("multi_cnt19", 32'(cnt0), 32'd6);

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            bit [2:0] f;
            bit fl, h;
            for (int k = 0; k < NS; k++) f[k] = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 7) == 0);
            if (i == 200) reset_seq("rndrst");
            cycle(f, fl, h);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_pipe_ctrl.md
Name: core_pipe_ctrl

Overview:
- Parametrised stage sequencer for the TOYCORE family; successor to the fixed 3-state IFU/IDU/EXU controller.
- Supports NSTAGE stages and two modes.
  - Multicycle mode keeps one instruction token in flight.
  - Pipelined mode keeps one token per stage, with per-stage backpressure, flush on redirect, fetch halt and a retire counter.
- Sits between the core's stage units (fetch/decode/execute/...) and drives their enables from their finish strobes.

Parameters:
- NSTAGE, 3, number of stages; must be ≥2.
- PIPE_MODE, 1, 0 = multicycle (one token in flight), 1 = pipelined.
- CNT_W, 32, width of the retired-instruction counter.
- IDX_W, 2, width of o_active_idx; must be ≥ clog2(NSTAGE).

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- i_stage_finish  in  NSTAGE  bit k: stage k completed work on its current token this cycle. Ignored unless o_stage_en[k]=1.
- i_flush  in  1  redirect (jump taken) from the last stage.
- i_halt  in  1  1 = inject no new tokens into stage 0.
- o_stage_en  out  NSTAGE  bit k: stage k holds a token not yet finished; the stage may work.
- o_stage_vld  out  NSTAGE  bit k: stage k holds a token (finished or not).
- o_busy  out  1  OR of o_stage_vld.
- o_retire  out  1  1-cycle pulse: last stage's token leaves this cycle.
- o_retire_cnt  out  CNT_W  count of retired tokens.
- o_active_idx  out  IDX_W  lowest k with vld[k]=1; 0 when empty.

Behaviour:
- State registers: vld[NSTAGE], done[NSTAGE], cnt[CNT_W].
- While i_rst=0, all state is cleared asynchronously. Outputs then: o_stage_en=0, o_stage_vld=0, o_busy=0, o_retire=0, o_retire_cnt=0, o_active_idx=0.
- Stage enable:
  - o_stage_en[k] = vld[k] & ~done[k].
  - fin[k] = vld[k] & (done[k] | (i_stage_finish[k] & ~done[k])).
- Advance, combinational, evaluated from the last stage downward:
  - adv[N-1] = fin[N-1].
  - adv[k] = fin[k] & (~vld[k+1] | adv[k+1]).
- o_retire = adv[N-1]. On retire, cnt <= cnt+1, wrapping modulo 2^CNT_W.
- Finished-but-blocked stage: a stage with fin[k]=1 and adv[k]=0 sets done[k]=1, holds vld[k]=1 and drops o_stage_en[k].
- Stage k advancing:
  - vld[k+1] <= 1 and done[k+1] <= 0 (fresh token enters k+1).
  - vld[k] is cleared unless refilled from k-1 in the same cycle.
- Injection into stage 0 requires i_halt=0, plus:
  - PIPE_MODE=1: ~vld[0] | adv[0].
  - PIPE_MODE=0: every vld bit will be 0 after this edge, i.e. the pipe is empty, or the only token is retiring this cycle.
  - Injection sets vld[0]=1, done[0]=0.
- Multicycle throughput: with finishes tied high, one stage per cycle; o_stage_en walks a one-hot 0→N-1 and repeats.
- Flush, when i_flush=1:
  - At the edge, vld and done of stages 0..N-2 are cleared.
  - Advances into stages 1..N-1 are suppressed.
  - Stage N-1 is unaffected; its own retire proceeds.
  - Stage 0 injects in the same cycle if i_halt=0, in either mode, regardless of occupancy. This is the redirected fetch.
- i_flush arriving with no valid downstream tokens is harmless.
- Halt: i_halt only blocks injection; tokens already in flight drain normally.
- Simultaneous i_flush and i_halt: flush clears the stages, no injection.
- Reset mid-operation: all tokens are discarded immediately; the counter is cleared.

Test Plan:
- NSTAGE=3, PIPE_MODE=0, finish=111, halt=0, release reset:
  - o_stage_en = 001,010,100,001,… from the first edge.
  - o_retire every 3rd cycle.
  - o_retire_cnt=10 after 30 cycles.
- PIPE_MODE=1, finish=111:
  - Cycles 1–2 fill; from cycle 3, o_stage_en=111 and o_retire=1 every cycle.
  - o_retire_cnt=8 after 10 cycles.
- PIPE_MODE=1 full, finish[2]=0 for 4 cycles:
  - o_stage_en=100, o_stage_vld=111 held; no retire.
  - On release: one retire per cycle, no token lost (count checked against injections).
- PIPE_MODE=1 full, i_flush=1 with finish[2]=1:
  - o_retire=1 that cycle.
  - Next cycle o_stage_vld=001, o_stage_en=001, o_retire_cnt +1 only.
- i_halt=1 with pipe full, finish=111:
  - o_stage_vld 111→110→100→000; o_busy=0 after 3 cycles.
  - o_active_idx reads 0,1,2,0.
- CNT_W=4:
  - 16 retires → o_retire_cnt=0.
  - i_rst=0 asserted mid-cycle → all outputs 0 before the next clock edge.
